// File: rtl/static_demux_if.sv
// -----------------------------------------------------------------------------
// static_demux_if
// Groups the control, stream and routed-output signals of static_demux.
//   run     : single-cycle start pulse
//   in0     : streamed data input
//   sel_00  : route select sampled at run (0 -> out0, 1 -> out1)
//   delay0  : idle cycles between run and the first sample
//   length  : number of samples to route
//   out0/1  : registered routed outputs, zero when not carrying a sample
//   valid0/1: the matching output carries a sample this cycle
//   done    : high while the block is idle
// The slave modport is the demux side; the master modport drives it.
// -----------------------------------------------------------------------------
interface static_demux_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 16,
  parameter int LEN_W   = 16
);
  logic               run;
  logic [DATA_W-1:0]  in0;
  logic               sel_00;
  logic [DELAY_W-1:0] delay0;
  logic [LEN_W-1:0]   length;
  logic [DATA_W-1:0]  out0;
  logic [DATA_W-1:0]  out1;
  logic               valid0;
  logic               valid1;
  logic               done;

  modport slave (
    input  run, in0, sel_00, delay0, length,
    output out0, out1, valid0, valid1, done
  );

  modport master (
    output run, in0, sel_00, delay0, length,
    input  out0, out1, valid0, valid1, done
  );
endinterface

// File: rtl/static_demux.sv
// -----------------------------------------------------------------------------
// static_demux
// On a run pulse, latches a route select, an idle delay and a sample count,
// waits the delay, then copies that many consecutive in0 samples to the
// selected output with a one-cycle registered latency.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides run)
//   bus  : static_demux_if.slave (run/in0/sel_00/delay0/length in,
//          out0/out1/valid0/valid1/done out)
// A run pulse in any state restarts the operation; a sample taken in the
// same cycle as the restart still emits on the previously latched route.
// -----------------------------------------------------------------------------
module static_demux #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 16,
  parameter int LEN_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  static_demux_if.slave  bus
);

  // One extra bit: a zero-length run waits delay0 + 1 cycles, which must not
  // wrap when delay0 is at its maximum.
  localparam int CNT_W = DELAY_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE
  } state_e;

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;  // WAIT cycles left, incl. current
  logic [LEN_W-1:0]    len_cnt_q,  len_cnt_d;   // samples left, incl. current
  logic                sel_q,      sel_d;
  logic [DATA_W-1:0]   out0_q,     out0_d;
  logic [DATA_W-1:0]   out1_q,     out1_d;
  logic                valid0_q,   valid0_d;
  logic                valid1_q,   valid1_d;

  logic [CNT_W-1:0]    wait_cycles;
  logic                sample;

  // A zero-length run still occupies the slot where its first sample would
  // have been, so done rises one cycle after that slot rather than at the
  // end of the delay.
  assign wait_cycles = {1'b0, bus.delay0} + CNT_W'(bus.length == '0);
  assign sample      = (state_q == S_ACTIVE);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    len_cnt_d  = len_cnt_q;
    sel_d      = sel_q;

    unique case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(1)) begin
          state_d = (len_cnt_q == '0) ? S_IDLE : S_ACTIVE;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (len_cnt_q == LEN_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          len_cnt_d = len_cnt_q - LEN_W'(1);
        end
      end
      default: ;
    endcase

    // A run pulse wins over the sequencing above, in any state.
    if (bus.run) begin
      sel_d      = bus.sel_00;
      len_cnt_d  = bus.length;
      wait_cnt_d = wait_cycles;
      state_d    = (wait_cycles == '0) ? S_ACTIVE : S_WAIT;
    end

    // The capture uses the select latched before this cycle, so a sample
    // taken alongside a restart stays on its original route.
    out0_d   = (sample && !sel_q) ? bus.in0 : '0;
    out1_d   = (sample &&  sel_q) ? bus.in0 : '0;
    valid0_d = sample && !sel_q;
    valid1_d = sample &&  sel_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      len_cnt_q  <= '0;
      sel_q      <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      len_cnt_q  <= len_cnt_d;
      sel_q      <= sel_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
    end
  end

  assign bus.out0   = out0_q;
  assign bus.out1   = out1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;
  assign bus.done   = (state_q == S_IDLE);

endmodule

// File: doc/static_demux.md
STATIC_DEMUX -- requirements
Module: static_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width.
REQ-002 SHALL have parameter DELAY_W, default 16, width of delay configuration.
REQ-003 SHALL have parameter LEN_W, default 16, width of length configuration.
REQ-004 SHALL use one clock and synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 run  input  1  single-cycle start pulse.
REQ-007 in0  input  DATA_W  streamed data input.
REQ-008 sel_00  input  1  static route select (0 -> out0, 1 -> out1).
REQ-009 delay0  input  DELAY_W  idle cycles between run and first sample.
REQ-010 length  input  LEN_W  number of samples to route.
REQ-011 out0  output  DATA_W  registered output, route 0.
REQ-012 out1  output  DATA_W  registered output, route 1.
REQ-013 valid0  output  1  out0 carries a routed sample this cycle.
REQ-014 valid1  output  1  out1 carries a routed sample this cycle.
REQ-015 done  output  1  high when idle.

Function
REQ-016 SHALL implement states IDLE, WAIT, ACTIVE.
REQ-017 run sampled high at cycle t, any state: SHALL latch sel_00, delay0 and length, load the delay counter and enter WAIT at t+1.
REQ-018 WAIT: SHALL stay exactly delay0 cycles, then enter ACTIVE; delay0=0: ACTIVE at t+1.
REQ-019 ACTIVE: SHALL sample in0 on each of length consecutive cycles, then return to IDLE.
REQ-020 length=0: WAIT SHALL go directly to IDLE, no valid asserted.
REQ-021 Sample taken at cycle k SHALL appear on the selected output with its valid at k+1 (1-cycle latency).
REQ-022 Non-selected output SHALL be 0 with valid low; selected output SHALL be 0 whenever its valid is low.
REQ-023 Route SHALL be the latched select; sel_00 changes after run SHALL have no effect until the next run.
REQ-024 done SHALL be 0 from t+1 until the cycle in which the last sample's valid is high, and 1 from that cycle on.
REQ-025 run during WAIT or ACTIVE SHALL abort the current operation and restart per REQ-017; samples already registered still emit at k+1.
REQ-026 run in the same cycle as the last ACTIVE sample: that sample SHALL emit; restart SHALL take effect and done SHALL stay 0.
REQ-027 Counters SHALL be wide enough for the maximum delay0 and length values without wrap-around.

Reset
REQ-028 rst SHALL override run.
REQ-029 rst high at a clock edge SHALL force IDLE, clear counters and latched config, set out0=out1=0, valid0=valid1=0, done=1 from the next cycle.
REQ-030 rst mid-operation SHALL discard remaining samples; no valid SHALL assert after reset until a new run.

Verification
REQ-031 sel_00=0, delay0=0, length=3, in0=A,B,C at t+1..t+3 -> out0=A,B,C, valid0=1 at t+2..t+4; out1=0, valid1=0; done=0 t+1..t+3, done=1 from t+4.
REQ-032 sel_00=1, delay0=2, length=2, in0=0x11,0x22 at t+3,t+4 -> out1=0x11,0x22 at t+4,t+5; valid0 never high.
REQ-033 length=0, delay0=1 -> no valid asserted; done low t+1..t+2, high from t+3.
REQ-034 run with sel_00=0, length=4; second run with sel_00=1, delay0=0, length=1 two cycles later -> first sample on out0 only; second run's sample on out1 one cycle after it is taken; done rises with it.
REQ-035 rst at second ACTIVE cycle of length=5 run -> all outputs 0, done=1 next cycle; no further valid.
REQ-036 sel_00 toggled every cycle during ACTIVE of length=4 -> all 4 samples on route latched at run.
